laplace_stream_ctrl: RTL and testbench

Sequencer that turns a raster-order 8-bit pixel stream (IMG_W x IMG_H frame) into the 5-point cross window (b,d,e,f,h) consumed by the combinational laplace9 kernels. It holds two line buffers and column shift registers, runs per-frame start/done control and valid/ready backpressure, and emits only interior windows: (IMG_W-2) x (IMG_H-2) per frame, matching the filtered-image format.

---
 rtl/laplace_pkg.sv | 21 ++
 rtl/laplace_line_buf.sv | 23 ++
 rtl/laplace_stream_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_laplace_stream_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/laplace_pkg.sv
// laplace_pkg: shared types and constants for the laplace stream controller
package laplace_pkg;

    localparam int DW_DEF = 8;

    localparam int TAP_B = 0;
    localparam int TAP_D = 1;
    localparam int TAP_E = 2;
    localparam int TAP_F = 3;
    localparam int TAP_H = 4;
    localparam int NTAP  = 5;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/laplace_line_buf.sv
// laplace_line_buf: one-row pixel store, single write port, asynchronous read
module laplace_line_buf #(
    parameter int DW = 8,
    parameter int N  = 512,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [N];

    // Row storage, written once per accepted pixel
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/laplace_stream_ctrl.sv
// laplace_stream_ctrl: raster stream to 5-point cross window sequencer
// Optional statistics outputs enabled by LAPLACE_CTRL_STATS_EN
module laplace_stream_ctrl
    import laplace_pkg::*;
#(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int DW    = DW_DEF,
    parameter int CW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_b,
    output logic [DW-1:0] out_d,
    output logic [DW-1:0] out_e,
    output logic [DW-1:0] out_f,
    output logic [DW-1:0] out_h,
    output logic [CW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_sof,
    output logic          out_eof,
    output logic          out_valid,
`ifdef LAPLACE_CTRL_STATS_EN
    output logic [15:0]     frame_cnt,
    output logic [2*CW-1:0] win_cnt,
`endif
    input  logic          out_ready
);

    localparam int AW = $clog2(IMG_W);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] TWO = CW'(2);
    localparam logic [CW-1:0] WL  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] HL  = CW'(IMG_H - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] r_q, r_d, c_q, c_d, row_q, row_d, col_q, col_d;
    logic [DW-1:0] b_q, b_d, d_q, d_d, e_q, e_d, h_q, h_d;
    logic [DW-1:0] tap_q [NTAP];
    logic [DW-1:0] tap_d [NTAP];
    logic          ov_q, ov_d, sof_q, sof_d, eof_q, eof_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [DW-1:0] lb1_rd, lb2_rd;
    logic          acc, win, last, first;

    assign in_ready = busy_q && (!ov_q || out_ready);
    assign acc      = in_valid && in_ready;
    assign first    = r_q == TWO && c_q == TWO;
    assign last     = r_q == HL && c_q == WL;
    assign win      = acc && r_q >= TWO && c_q >= TWO;

    laplace_line_buf #(.DW(DW), .N(IMG_W), .AW(AW)) u_lb1 (
        .clk(clk), .we(acc), .addr(c_q[AW-1:0]), .wdata(in_data), .rdata(lb1_rd)
    );

    laplace_line_buf #(.DW(DW), .N(IMG_W), .AW(AW)) u_lb2 (
        .clk(clk), .we(acc), .addr(c_q[AW-1:0]), .wdata(lb1_rd), .rdata(lb2_rd)
    );

    // Next-state: frame control, raster counters, column shift and output window
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        b_d     = b_q;
        d_d     = d_q;
        e_d     = e_q;
        h_d     = h_q;
        tap_d   = tap_q;
        row_d   = row_q;
        col_d   = col_q;
        sof_d   = sof_q;
        eof_d   = eof_q;
        case (state_q)
            IDLE:     state_d = start ? FILL : IDLE;
            FILL,
            RUN:      state_d = (acc && last) ? DRAIN : (acc && first) ? RUN : state_q;
            DRAIN:    state_d = (ov_q && out_ready) ? DONE : DRAIN;
            default:  state_d = IDLE;
        endcase
        if (state_q == IDLE && start) begin
            r_d = '0;
            c_d = '0;
        end
        if (acc) begin
            c_d = (c_q == WL) ? '0 : c_q + ONE;
            r_d = (c_q == WL) ? ((r_q == HL) ? '0 : r_q + ONE) : r_q;
            d_d = (c_q == '0) ? '0 : e_q;
            e_d = lb1_rd;
            h_d = in_data;
            b_d = lb2_rd;
        end
        if (win) begin
            tap_d[TAP_B] = b_q;
            tap_d[TAP_D] = d_q;
            tap_d[TAP_E] = e_q;
            tap_d[TAP_F] = lb1_rd;
            tap_d[TAP_H] = h_q;
            row_d        = r_q - ONE;
            col_d        = c_q - ONE;
            sof_d        = first;
            eof_d        = last;
        end
        ov_d   = win ? 1'b1 : (out_ready ? 1'b0 : ov_q);
        busy_d = state_d == FILL || state_d == RUN;
        done_d = state_d == DONE;
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            h_q     <= '0;
            tap_q   <= '{default: '0};
            row_q   <= '0;
            col_q   <= '0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            b_q     <= b_d;
            d_q     <= d_d;
            e_q     <= e_d;
            h_q     <= h_d;
            tap_q   <= tap_d;
            row_q   <= row_d;
            col_q   <= col_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_b     = tap_q[TAP_B];
    assign out_d     = tap_q[TAP_D];
    assign out_e     = tap_q[TAP_E];
    assign out_f     = tap_q[TAP_F];
    assign out_h     = tap_q[TAP_H];
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_sof   = sof_q;
    assign out_eof   = eof_q;
    assign out_valid = ov_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef LAPLACE_CTRL_STATS_EN
    logic [15:0]     frame_q, frame_d;
    logic [2*CW-1:0] win_q, win_d;

    // Frame count advances on done; window count restarts with each frame
    always_comb begin
        frame_d = frame_q + 16'(state_q == DONE);
        win_d   = (state_q == IDLE && start) ? '0 : win_q + (2*CW)'(ov_q && out_ready);
    end

    // Statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
            win_q   <= '0;
        end else begin
            frame_q <= frame_d;
            win_q   <= win_d;
        end
    end

    assign frame_cnt = frame_q;
    assign win_cnt   = win_q;
`endif

endmodule

// File: tb/tb_laplace_stream_ctrl.sv
// tb_laplace_stream_ctrl: scoreboard bench for the laplace stream controller
module tb_laplace_stream_ctrl;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int CW = 10;

    logic          clk = 0;
    logic          rst = 1;
    logic          start = 0;
    logic          in_valid = 0;
    logic          out_ready = 0;
    logic [DW-1:0] in_data = '0;
    logic          busy, done, in_ready, out_sof, out_eof, out_valid;
    logic [DW-1:0] out_b, out_d, out_e, out_f, out_h;
    logic [CW-1:0] out_row, out_col;
`ifdef LAPLACE_CTRL_STATS_EN
    logic [15:0]     frame_cnt;
    logic [2*CW-1:0] win_cnt;
`endif

    laplace_stream_ctrl #(.IMG_W(W), .IMG_H(H), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_b(out_b), .out_d(out_d), .out_e(out_e), .out_f(out_f), .out_h(out_h),
        .out_row(out_row), .out_col(out_col), .out_sof(out_sof), .out_eof(out_eof),
        .out_valid(out_valid),
`ifdef LAPLACE_CTRL_STATS_EN
        .frame_cnt(frame_cnt), .win_cnt(win_cnt),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] b, d, e, f, h;
        logic [CW-1:0] row, col;
        logic          sof, eof;
    } win_t;

    win_t sbq[$];
    int   total = 0;
    int   bad = 0;

    function automatic logic [DW-1:0] pix(input int r, input int c);
        return DW'(r * 16 + c);
    endfunction

    function automatic win_t model(input int r, input int c);
        win_t w;
        w.b   = pix(r - 2, c - 1);
        w.d   = pix(r - 1, c - 2);
        w.e   = pix(r - 1, c - 1);
        w.f   = pix(r - 1, c);
        w.h   = pix(r, c - 1);
        w.row = CW'(r - 1);
        w.col = CW'(c - 1);
        w.sof = r == 2 && c == 2;
        w.eof = r == H - 1 && c == W - 1;
        return w;
    endfunction

    task automatic pulse_start;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL start_busy got=%b want=1", busy);
        end
    endtask

    // mode 0: full rate, 1: out_ready 1-0-0-1, 2: random in_valid, 3: stray start mid-frame
    task automatic drive_frame(input int mode, input int abort_k);
        int   k = 0;
        int   cyc = 0;
        int   nwin = 0;
        int   dones = 0;
        bit   exp_done = 0;
        bit   fin = 0;
        win_t w, got;
        while (!fin && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            in_valid  = (k < W * H) && (mode == 2 ? $urandom_range(0, 1) == 1 : 1'b1);
            in_data   = pix(k / W, k % W);
            out_ready = mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            start     = mode == 3 && cyc == 8;
            if (k == abort_k) begin
                rst = 1;
                #1;
                total++;
                got = {out_b, out_d, out_e, out_f, out_h, out_row, out_col, out_sof, out_eof};
                if ({got, out_valid, in_ready, busy, done} !== '0) begin
                    bad++;
                    $display("FAIL reset_mid got=%h v=%b ir=%b busy=%b done=%b want=all 0", got, out_valid, in_ready, busy, done);
                end
                sbq.delete();
                in_valid = 0;
                @(negedge clk) rst = 0;
                return;
            end
            @(negedge clk);
            total++;
            if (done !== exp_done) begin
                bad++;
                $display("FAIL done_pulse cyc=%0d got=%b want=%b", cyc, done, exp_done);
            end
            if (done) begin
                dones++;
                fin = 1;
            end
            exp_done = 0;
            if (out_valid && out_ready) begin
                total++;
                got = {out_b, out_d, out_e, out_f, out_h, out_row, out_col, out_sof, out_eof};
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL window_extra got=%h want=none", got);
                end else begin
                    w = sbq.pop_front();
                    nwin++;
                    if (got !== w) begin
                        bad++;
                        $display("FAIL window_%0d got=%h want=%h", nwin, got, w);
                    end
                    exp_done = w.eof;
                end
            end
            if (out_valid && !out_ready) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_in_ready got=%b want=0", in_ready);
                end
            end
            if (in_valid && in_ready) begin
                if (k / W >= 2 && k % W >= 2) sbq.push_back(model(k / W, k % W));
                k++;
            end
        end
        in_valid = 0;
        start    = 0;
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL frame_timeout got=no done want=done within 300 cycles");
        end
        total++;
        if (nwin != (W - 2) * (H - 2) || sbq.size() != 0) begin
            bad++;
            $display("FAIL window_count got=%0d left=%0d want=%0d left=0", nwin, sbq.size(), (W - 2) * (H - 2));
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL done_count got=%0d want=1", dones);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after got busy=%b v=%b done=%b want=0 0 0", busy, out_valid, done);
        end
    endtask

    task automatic test_reset;
        win_t got;
        repeat (3) @(negedge clk);
        total++;
        got = {out_b, out_d, out_e, out_f, out_h, out_row, out_col, out_sof, out_eof};
        if ({got, out_valid, in_ready, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset_state got=%h v=%b ir=%b busy=%b done=%b want=all 0", got, out_valid, in_ready, busy, done);
        end
        rst = 0;
    endtask

    task automatic test_stream;
        pulse_start();
        drive_frame(0, -1);
    endtask

    task automatic test_backpressure;
        pulse_start();
        drive_frame(1, -1);
    endtask

    task automatic test_random_valid;
        pulse_start();
        drive_frame(2, -1);
    endtask

    task automatic test_start_ignored;
        pulse_start();
        drive_frame(3, -1);
    endtask

    task automatic test_reset_midframe;
        pulse_start();
        drive_frame(0, 2 * W + 3);
        pulse_start();
        drive_frame(0, -1);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_random_valid();
        test_start_ignored();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
